// File: rtl/spi_mem_pkg.sv
// ----------------------------------------------------------------------------
// spi_mem_pkg
// Shared constants and types for the serial-EEPROM command sequencer:
//   - EEPROM command bytes and the dummy byte clocked out during reads
//   - status register WIP bit position
//   - sequencer FSM state encoding
// ----------------------------------------------------------------------------
package spi_mem_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] DUMMY     = 8'hFF;
    localparam int         WIP_BIT   = 0;

    // Byte index where a write re-enters the status poll (RDSR command byte)
    localparam logic [2:0] IDX_RDSR  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3,
        S_EVAL  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

endpackage

// File: rtl/spi_mem_sequencer_bytesel.sv
// ----------------------------------------------------------------------------
// spi_mem_sequencer_bytesel
// Combinational byte-list decoder. For the current request type and byte
// index it returns the byte to send, whether CE stays low after it, and
// whether this is the final byte of the list (the byte whose received value
// is evaluated).
// Ports:
//   write     in  1 : 1 = write sequence, 0 = read sequence
//   idx       in  3 : byte index within the sequence
//   addr      in 16 : latched memory address
//   wdata     in  8 : latched write data
//   tx        out 8 : byte to send
//   cont      out 1 : keep CE low after this byte
//   last      out 1 : final byte of the list
// ----------------------------------------------------------------------------
module spi_mem_sequencer_bytesel
    import spi_mem_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  idx,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  tx,
    output logic        cont,
    output logic        last
);

    // Decode (byte, continued, last) from the request type and index
    always_comb begin
        tx   = DUMMY;
        cont = 1'b0;
        last = 1'b0;
        if (write) begin
            // WREN stands alone (CE break latches the write-enable), the
            // WRITE frame ends after the data byte, and each RDSR poll is
            // its own two-byte frame.
            case (idx)
                3'd0:    begin tx = CMD_WREN;    cont = 1'b0; end
                3'd1:    begin tx = CMD_WRITE;   cont = 1'b1; end
                3'd2:    begin tx = addr[15:8];  cont = 1'b1; end
                3'd3:    begin tx = addr[7:0];   cont = 1'b1; end
                3'd4:    begin tx = wdata;       cont = 1'b0; end
                3'd5:    begin tx = CMD_RDSR;    cont = 1'b1; end
                3'd6:    begin tx = DUMMY;       cont = 1'b0; last = 1'b1; end
                default: begin tx = DUMMY;       cont = 1'b0; last = 1'b1; end
            endcase
        end else begin
            case (idx)
                3'd0:    begin tx = CMD_READ;    cont = 1'b1; end
                3'd1:    begin tx = addr[15:8];  cont = 1'b1; end
                3'd2:    begin tx = addr[7:0];   cont = 1'b1; end
                3'd3:    begin tx = DUMMY;       cont = 1'b0; last = 1'b1; end
                default: begin tx = DUMMY;       cont = 1'b0; last = 1'b1; end
            endcase
        end
    end

endmodule

// File: rtl/spi_mem_sequencer.sv
// ----------------------------------------------------------------------------
// spi_mem_sequencer
// Expands single-byte memory read/write requests into serial-EEPROM byte
// sequences and drives the SPI byte engine start/continued/tx handshake one
// byte at a time. Writes are followed by RDSR polling until WIP clears or
// the poll limit is reached.
// Parameters:
//   ADDR_W   : address width (16, sent MSB first as two bytes)
//   POLL_MAX : maximum RDSR polls before flagging an error
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready = idle)
//   req_write/addr/wdata : request fields
//   rsp_valid            : one-cycle completion strobe
//   rsp_rdata, rsp_err   : read data (held until next read), poll-limit error
//   spi_start            : one-cycle start pulse to the byte engine
//   spi_continued        : keep CE low after this byte
//   spi_tx, spi_rx       : byte sent / byte received
//   spi_ready            : byte engine idle
// ----------------------------------------------------------------------------
module spi_mem_sequencer
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int POLL_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic              spi_start,
    output logic              spi_continued,
    output logic [7:0]        spi_tx,
    input  logic [7:0]        spi_rx,
    input  logic              spi_ready
);

    localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);

    state_t        state_r,  state_next_s;
    logic [2:0]    idx_r,    idx_next_s;
    logic [7:0]    poll_r,   poll_next_s;
    logic [7:0]    poll_inc_s;
    logic          write_r,  write_next_s;
    logic [15:0]   addr_r,   addr_next_s;
    logic [7:0]    wdata_r,  wdata_next_s;
    logic [7:0]    rx_r,     rx_next_s;

    logic          start_r,  start_next_s;
    logic          cont_r,   cont_next_s;
    logic [7:0]    tx_r,     tx_next_s;
    logic          valid_r,  valid_next_s;
    logic [7:0]    rdata_r,  rdata_next_s;
    logic          err_r,    err_next_s;

    logic [7:0]    sel_tx_s;
    logic          sel_cont_s;
    logic          sel_last_s;

    spi_mem_sequencer_bytesel u_bytesel (
        .write (write_r),
        .idx   (idx_r),
        .addr  (addr_r),
        .wdata (wdata_r),
        .tx    (sel_tx_s),
        .cont  (sel_cont_s),
        .last  (sel_last_s)
    );

    assign poll_inc_s = poll_r + 8'd1;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, counter and output-register next values
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        poll_next_s  = poll_r;
        write_next_s = write_r;
        addr_next_s  = addr_r;
        wdata_next_s = wdata_r;
        rx_next_s    = rx_r;
        start_next_s = 1'b0;
        cont_next_s  = cont_r;
        tx_next_s    = tx_r;
        valid_next_s = 1'b0;
        rdata_next_s = rdata_r;
        err_next_s   = err_r;

        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    write_next_s = req_write;
                    addr_next_s  = req_addr[15:0];
                    wdata_next_s = req_wdata;
                    idx_next_s   = 3'd0;
                    poll_next_s  = 8'd0;
                    state_next_s = S_ISSUE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                // tx/continued only change together with the start pulse,
                // so the engine sees them stable for the whole byte.
                if (spi_ready) begin
                    start_next_s = 1'b1;
                    tx_next_s    = sel_tx_s;
                    cont_next_s  = sel_cont_s;
                    state_next_s = S_ARM;
                end else begin
                    state_next_s = S_ISSUE;
                end
            end
            S_ARM: begin
                // The engine drops ready once it has taken the start pulse
                if (!spi_ready) begin
                    state_next_s = S_WAIT;
                end else begin
                    state_next_s = S_ARM;
                end
            end
            S_WAIT: begin
                if (spi_ready) begin
                    rx_next_s    = spi_rx;
                    state_next_s = S_EVAL;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_EVAL: begin
                if (!sel_last_s) begin
                    idx_next_s   = idx_r + 3'd1;
                    state_next_s = S_ISSUE;
                end else if (!write_r) begin
                    rdata_next_s = rx_r;
                    err_next_s   = 1'b0;
                    valid_next_s = 1'b1;
                    state_next_s = S_RESP;
                end else if (rx_r[WIP_BIT] == 1'b0) begin
                    err_next_s   = 1'b0;
                    valid_next_s = 1'b1;
                    state_next_s = S_RESP;
                end else if (poll_inc_s == POLL_LIMIT) begin
                    poll_next_s  = poll_inc_s;
                    err_next_s   = 1'b1;
                    valid_next_s = 1'b1;
                    state_next_s = S_RESP;
                end else begin
                    // Still busy: send another RDSR frame
                    poll_next_s  = poll_inc_s;
                    idx_next_s   = IDX_RDSR;
                    state_next_s = S_ISSUE;
                end
            end
            S_RESP: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r   <= 3'd0;
            poll_r  <= 8'd0;
            write_r <= 1'b0;
            addr_r  <= 16'h0000;
            wdata_r <= 8'h00;
            rx_r    <= 8'h00;
            start_r <= 1'b0;
            cont_r  <= 1'b0;
            tx_r    <= DUMMY;
            valid_r <= 1'b0;
            rdata_r <= 8'h00;
            err_r   <= 1'b0;
        end else begin
            idx_r   <= idx_next_s;
            poll_r  <= poll_next_s;
            write_r <= write_next_s;
            addr_r  <= addr_next_s;
            wdata_r <= wdata_next_s;
            rx_r    <= rx_next_s;
            start_r <= start_next_s;
            cont_r  <= cont_next_s;
            tx_r    <= tx_next_s;
            valid_r <= valid_next_s;
            rdata_r <= rdata_next_s;
            err_r   <= err_next_s;
        end
    end

    assign req_ready     = (state_r == S_IDLE);
    assign spi_start     = start_r;
    assign spi_continued = cont_r;
    assign spi_tx        = tx_r;
    assign rsp_valid     = valid_r;
    assign rsp_rdata     = rdata_r;
    assign rsp_err       = err_r;

endmodule

// File: tb/tb_spi_mem_sequencer.sv
// ----------------------------------------------------------------------------
// tb_spi_mem_sequencer
// Table-driven bench for spi_mem_sequencer with a small byte-engine/EEPROM
// model. POLL_MAX is 3 so the poll-limit path is reachable quickly.
// ----------------------------------------------------------------------------
module tb_spi_mem_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        spi_start;
    logic        spi_continued;
    logic [7:0]  spi_tx;
    logic [7:0]  spi_rx;
    logic        spi_ready;

    spi_mem_sequencer #(.ADDR_W(16), .POLL_MAX(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .spi_start     (spi_start),
        .spi_continued (spi_continued),
        .spi_tx        (spi_tx),
        .spi_rx        (spi_rx),
        .spi_ready     (spi_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- byte engine / EEPROM model ----------------
    logic       hold_busy;     // forces engine ready low
    logic [7:0] wip_ones;      // number of RDSR replies with WIP=1 (FF = stuck)
    logic [7:0] rd_val;        // value returned on the read data byte
    logic       eng_ready_r;
    logic [2:0] eng_cnt_r;
    logic [7:0] eng_rx_r;
    logic [7:0] last_tx_r;
    logic [7:0] stat_cnt_r;

    assign spi_ready = eng_ready_r && !hold_busy;
    assign spi_rx    = eng_rx_r;

    // Engine: 3-cycle busy per byte; reply depends on the previous byte
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_ready_r <= 1'b1;
            eng_cnt_r   <= 3'd0;
            eng_rx_r    <= 8'h00;
            last_tx_r   <= 8'h00;
            stat_cnt_r  <= 8'd0;
        end else begin
            if (req_valid && req_ready) stat_cnt_r <= 8'd0;
            if (eng_cnt_r != 3'd0) begin
                eng_cnt_r <= eng_cnt_r - 3'd1;
                if (eng_cnt_r == 3'd1) eng_ready_r <= 1'b1;
            end else if (spi_start && spi_ready) begin
                eng_ready_r <= 1'b0;
                eng_cnt_r   <= 3'd3;
                last_tx_r   <= spi_tx;
                if (last_tx_r == 8'h05) begin
                    eng_rx_r   <= (wip_ones == 8'hFF || stat_cnt_r < wip_ones) ? 8'h01 : 8'h00;
                    stat_cnt_r <= stat_cnt_r + 8'd1;
                end else if (spi_tx == 8'hFF && !spi_continued) begin
                    eng_rx_r <= rd_val;
                end else begin
                    eng_rx_r <= 8'h00;
                end
            end
        end
    end

    // ---------------- byte monitor ----------------
    logic [7:0] mon_tx[$];
    logic       mon_cont[$];
    int         start_viol;

    initial start_viol = 0;

    // Record every started byte; a start while the engine is busy is a violation
    always @(posedge clk) begin
        if (rst && spi_start) begin
            mon_tx.push_back(spi_tx);
            mon_cont.push_back(spi_continued);
            if (!spi_ready) start_viol <= start_viol + 1;
        end
    end

    // ---------------- vectors ----------------
    typedef struct packed {
        logic             write;
        logic [15:0]      addr;
        logic [7:0]       wdata;
        logic [7:0]       wip;
        logic [7:0]       rdv;
        logic [4:0]       exp_n;
        logic [0:15][7:0] exp_tx;
        logic [0:15]      exp_cont;
        logic [7:0]       exp_rdata;
        logic             exp_err;
    } vec_t;

    vec_t vecs [6];
    int   n_vec;
    int   n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [15:0] a, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (!ok) chk("req_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(output logic [7:0] rd, output logic er);
        bit found;
        found = 1'b0;
        rd = 8'h00;
        er = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (rsp_valid) begin
                found = 1'b1;
                rd = rsp_rdata;
                er = rsp_err;
                break;
            end
            @(negedge clk);
        end
        chk("rsp_seen", {31'd0, found}, 32'd1);
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int          base;
        logic [7:0]  rd;
        logic        er;
        base     = mon_tx.size();
        wip_ones = v.wip;
        rd_val   = v.rdv;
        do_req(v.write, v.addr, v.wdata);
        wait_rsp(rd, er);
        chk($sformatf("v%0d_nbytes", k), mon_tx.size() - base, {27'd0, v.exp_n});
        for (int i = 0; i < int'(v.exp_n); i++) begin
            if (base + i < mon_tx.size()) begin
                chk($sformatf("v%0d_tx%0d", k, i), {24'd0, mon_tx[base+i]}, {24'd0, v.exp_tx[i]});
                chk($sformatf("v%0d_cont%0d", k, i), {31'd0, mon_cont[base+i]}, {31'd0, v.exp_cont[i]});
            end
        end
        chk($sformatf("v%0d_rdata", k), {24'd0, rd}, {24'd0, v.exp_rdata});
        chk($sformatf("v%0d_err", k), {31'd0, er}, {31'd0, v.exp_err});
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;
        logic [7:0] tx_hold;
        int         base;
        bit         reached;
        int         acc, rsp_cyc, acc2;
        logic [7:0] first_rd;

        n_vec = 0;
        n_bad = 0;

        //           wr    addr      wdata  wip    rdv    n      tx bytes                                     cont                     rdata  err
        vecs[0] = '{1'b0, 16'h1234, 8'h00, 8'h00, 8'hA5, 5'd4,  128'h031234FF_00000000_00000000_00000000, 16'b1110_0000_0000_0000, 8'hA5, 1'b0};
        vecs[1] = '{1'b1, 16'h00FF, 8'h5A, 8'h02, 8'h00, 5'd11, 128'h060200FF_5A05FF05_FF05FF00_00000000, 16'b0111_0101_0100_0000, 8'hA5, 1'b0};
        vecs[2] = '{1'b1, 16'hABCD, 8'hC3, 8'h00, 8'h00, 5'd7,  128'h0602ABCD_C305FF00_00000000_00000000, 16'b0111_0100_0000_0000, 8'hA5, 1'b0};
        vecs[3] = '{1'b1, 16'h8001, 8'h11, 8'hFF, 8'h00, 5'd11, 128'h06028001_1105FF05_FF05FF00_00000000, 16'b0111_0101_0100_0000, 8'hA5, 1'b1};
        vecs[4] = '{1'b0, 16'hFFFE, 8'h00, 8'h00, 8'h3C, 5'd4,  128'h03FFFEFF_00000000_00000000_00000000, 16'b1110_0000_0000_0000, 8'h3C, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 8'h00, 8'h00, 8'h81, 5'd4,  128'h030000FF_00000000_00000000_00000000, 16'b1110_0000_0000_0000, 8'h81, 1'b0};

        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 8'h00;
        hold_busy = 1'b0;
        wip_ones  = 8'h00;
        rd_val    = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_spi_start", {31'd0, spi_start}, 32'd0);
        chk("rst_spi_cont",  {31'd0, spi_continued}, 32'd0);
        chk("rst_spi_tx",    {24'd0, spi_tx}, 32'h0000_00FF);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven transactions
        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], k);
        end

        // Engine busy while the sequencer sits in S_ISSUE
        base      = mon_tx.size();
        hold_busy = 1'b1;
        rd_val    = 8'h77;
        wip_ones  = 8'h00;
        do_req(1'b0, 16'h2222, 8'h00);
        tx_hold = spi_tx;
        for (int i = 0; i < 20; i++) begin
            chk("hold_no_start", {31'd0, spi_start}, 32'd0);
            chk("hold_tx_stable", {24'd0, spi_tx}, {24'd0, tx_hold});
            chk("hold_busy_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        chk("hold_no_bytes", mon_tx.size() - base, 32'd0);
        hold_busy = 1'b0;
        wait_rsp(rd, er);
        chk("hold_rdata", {24'd0, rd}, 32'h0000_0077);
        chk("hold_nbytes", mon_tx.size() - base, 32'd4);
        if (mon_tx.size() > base) chk("hold_byte0", {24'd0, mon_tx[base]}, 32'h0000_0003);

        // Reset in the middle of a read (during byte idx2)
        base    = mon_tx.size();
        rd_val  = 8'h99;
        do_req(1'b0, 16'h1234, 8'h00);
        reached = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (mon_tx.size() >= base + 3) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_reached_idx2", {31'd0, reached}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_spi_start", {31'd0, spi_start}, 32'd0);
        chk("mid_spi_cont",  {31'd0, spi_continued}, 32'd0);
        chk("mid_spi_tx",    {24'd0, spi_tx}, 32'h0000_00FF);
        chk("mid_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("mid_rsp_err",   {31'd0, rsp_err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_after_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        run_vec(vecs[0], 10);

        // Back-to-back requests with req_valid held high
        rd_val    = 8'h42;
        acc       = 0;
        rsp_cyc   = -1;
        acc2      = -1;
        first_rd  = 8'h00;
        @(negedge clk);
        req_write = 1'b0;
        req_addr  = 16'h0102;
        req_wdata = 8'h00;
        req_valid = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (rsp_valid && rsp_cyc < 0) begin
                rsp_cyc  = c;
                first_rd = rsp_rdata;
                chk("b2b_ready_in_resp", {31'd0, req_ready}, 32'd0);
            end
            if (req_ready) begin
                if (acc == 0) begin
                    acc = 1;
                end else begin
                    acc2 = c;
                    break;
                end
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_first_rsp", (rsp_cyc >= 0) ? 32'd1 : 32'd0, 32'd1);
        chk("b2b_second_accept", acc2, rsp_cyc + 1);
        chk("b2b_first_rdata", {24'd0, first_rd}, 32'h0000_0042);
        wait_rsp(rd, er);
        chk("b2b_second_rdata", {24'd0, rd}, 32'h0000_0042);

        chk("start_while_busy", start_viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
